// File: rtl/sha3_sched_pkg.sv
// Shared types and helpers for the SHA-3 permutation scheduler.
//   KECCAK_STATE_W : width of one Keccak-f[1600] state
//   keccak_state_t : one packed state
//   sched_state_e  : scheduler FSM encoding (QUIET after reset, RUN otherwise)
//   rr_pick()      : round-robin one-hot pick over up to MAX_REQ requesters
package sha3_sched_pkg;

    localparam int KECCAK_STATE_W = 1600;
    localparam int MAX_REQ        = 8;

    typedef logic [KECCAK_STATE_W-1:0] keccak_state_t;

    typedef enum logic [0:0] {
        ST_QUIET = 1'b0,
        ST_RUN   = 1'b1
    } sched_state_e;

    // First set bit of valid at or after ptr, wrapping within n requesters.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int                 idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            if ((k < n) && !found && valid[idx[2:0]]) begin
                grant[idx[2:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/sha3_perm_scheduler_if.sv
// Requester-side bus of the permutation scheduler.
//   req_valid/req_state/req_ready : issue handshake, state i at [i*1600 +: 1600]
//   rsp_valid/rsp_state           : one-hot result strobe and shared result state
// master = absorb/squeeze front-ends, slave = scheduler.
interface sha3_perm_scheduler_if #(
    parameter int N_REQ = 4
);
    import sha3_sched_pkg::*;

    logic [N_REQ-1:0]                req_valid;
    logic [N_REQ*KECCAK_STATE_W-1:0] req_state;
    logic [N_REQ-1:0]                req_ready;
    logic [N_REQ-1:0]                rsp_valid;
    keccak_state_t                   rsp_state;

    modport master (
        output req_valid, req_state,
        input  req_ready, rsp_valid, rsp_state
    );

    modport slave (
        input  req_valid, req_state,
        output req_ready, rsp_valid, rsp_state
    );

endinterface

// File: rtl/sha3_tag_fifo.sv
// In-order tag FIFO recording which requester issued each in-flight permutation.
//   clk, rst_n          : clock, async active-low reset
//   push, push_data     : enqueue a tag
//   pop, pop_data       : dequeue head (pop_data is the current head)
//   empty, full, level  : occupancy status
// A pop on an empty FIFO is ignored; a push on a full FIFO is accepted only
// together with a pop in the same cycle.
module sha3_tag_fifo #(
    parameter int TAG_W = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [TAG_W-1:0]         push_data,
    input  logic                     pop,
    output logic [TAG_W-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [TAG_W-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_en_s;
    logic             pop_en_s;

    assign level     = wr_ptr_r - rd_ptr_r;
    assign empty     = (level == '0);
    assign full      = (level == (AW+1)'(DEPTH));
    assign pop_en_s  = pop && !empty;
    assign push_en_s = push && (!full || pop_en_s);
    assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

    // Tag storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers with wrap bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/sha3_perm_scheduler.sv
// Shares one fixed-latency Keccak-f[1600] pipeline among N_REQ requesters.
//   clk, rst_n           : clock, async active-low reset
//   req_bus (slave)      : requester handshake and one-hot result strobe
//   perm_state_o/sample  : registered issue to the round chain
//   perm_state_i/good_i  : result from the round chain
//   busy                 : work in flight or post-reset quiet period
//   err_orphan           : sticky, a result arrived with no tag outstanding
// Optional: define SHA3_PERM_SCHEDULER_PERF_EN to add perf_issued/perf_stall.
module sha3_perm_scheduler
    import sha3_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int MAX_INFLIGHT = 8,
    parameter int PERM_LATENCY = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha3_perm_scheduler_if.slave req_bus,
    output keccak_state_t        perm_state_o,
    output logic                 perm_sample_o,
    input  keccak_state_t        perm_state_i,
    input  logic                 perm_good_i,
    output logic                 busy,
    output logic                 err_orphan
`ifdef SHA3_PERM_SCHEDULER_PERF_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_stall
`endif
);
    localparam int TAG_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W  = $clog2(MAX_INFLIGHT) + 1;
    localparam int QCNT_W = $clog2(PERM_LATENCY + 1) + 1;
    localparam logic [CNT_W-1:0]  MAX_CNT    = CNT_W'(MAX_INFLIGHT);
    localparam logic [QCNT_W-1:0] QUIET_LAST = QCNT_W'(PERM_LATENCY);

    sched_state_e        state_r, state_s;
    logic [QCNT_W-1:0]   quiet_cnt_r, quiet_cnt_s;
    logic [TAG_W-1:0]    ptr_r;
    logic [MAX_REQ-1:0]  pick_s;
    logic [N_REQ-1:0]    grant_s;
    logic [TAG_W-1:0]    grant_idx_s;
    logic                issue_s, ret_s, orphan_s;
    logic [TAG_W-1:0]    tag_s;
    logic                empty_s, full_s;
    logic [CNT_W-1:0]    level_s, level_next_s;

    keccak_state_t       perm_state_r, rsp_state_r;
    logic                perm_sample_r, busy_r, err_orphan_r;
    logic [N_REQ-1:0]    rsp_valid_r;

    // FSM state and quiet-period counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_QUIET;
            quiet_cnt_r <= '0;
        end else begin
            state_r     <= state_s;
            quiet_cnt_r <= quiet_cnt_s;
        end
    end

    // Next state: stay quiet for PERM_LATENCY+1 cycles so pre-reset results drain
    always_comb begin
        state_s     = state_r;
        quiet_cnt_s = quiet_cnt_r;
        case (state_r)
            ST_QUIET: begin
                if (quiet_cnt_r == QUIET_LAST) begin
                    state_s = ST_RUN;
                end else begin
                    quiet_cnt_s = quiet_cnt_r + QCNT_W'(1);
                end
            end
            ST_RUN:  state_s = ST_RUN;
            default: state_s = ST_QUIET;
        endcase
    end

    // Grant from registered state only; perm_good_i never feeds req_ready
    always_comb begin
        pick_s      = rr_pick(MAX_REQ'(req_bus.req_valid), 3'(ptr_r), N_REQ);
        grant_s     = '0;
        grant_idx_s = '0;
        if ((state_r == ST_RUN) && (level_s < MAX_CNT)) begin
            grant_s = pick_s[N_REQ-1:0];
        end else begin
            grant_s = '0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            grant_idx_s = grant_idx_s | (grant_s[i] ? TAG_W'(i) : TAG_W'(0));
        end
    end

    assign issue_s      = |grant_s;
    assign ret_s        = (state_r == ST_RUN) && perm_good_i && !empty_s;
    assign orphan_s     = (state_r == ST_RUN) && perm_good_i && empty_s;
    assign level_next_s = level_s + CNT_W'(issue_s) - CNT_W'(ret_s);

    sha3_tag_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (issue_s),
        .push_data (grant_idx_s),
        .pop       (ret_s),
        .pop_data  (tag_s),
        .empty     (empty_s),
        .full      (full_s),
        .level     (level_s)
    );

    // Issue, return, pointer and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r         <= '0;
            perm_state_r  <= '0;
            perm_sample_r <= 1'b0;
            rsp_valid_r   <= '0;
            rsp_state_r   <= '0;
            err_orphan_r  <= 1'b0;
            busy_r        <= 1'b1;
        end else begin
            perm_sample_r <= issue_s;
            if (issue_s) begin
                perm_state_r <= req_bus.req_state[int'(grant_idx_s)*KECCAK_STATE_W +: KECCAK_STATE_W];
                ptr_r        <= (grant_idx_s == TAG_W'(N_REQ-1)) ? TAG_W'(0) : grant_idx_s + TAG_W'(1);
            end
            rsp_valid_r <= ret_s ? (N_REQ'(1'b1) << tag_s) : '0;
            if (ret_s) begin
                rsp_state_r <= perm_state_i;
            end
            err_orphan_r <= err_orphan_r | orphan_s;
            busy_r       <= (state_s == ST_QUIET) || (level_next_s != '0);
        end
    end

    assign req_bus.req_ready = grant_s;
    assign req_bus.rsp_valid = rsp_valid_r;
    assign req_bus.rsp_state = rsp_state_r;
    assign perm_state_o      = perm_state_r;
    assign perm_sample_o     = perm_sample_r;
    assign busy              = busy_r;
    assign err_orphan        = err_orphan_r;

`ifdef SHA3_PERM_SCHEDULER_PERF_EN
    logic [31:0] perf_issued_r, perf_stall_r;
    logic        stall_s;

    assign stall_s = (state_r == ST_RUN) && (|req_bus.req_valid) && (level_s >= MAX_CNT);

    // Wrapping issue and in-flight-limit stall counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_r <= '0;
            perf_stall_r  <= '0;
        end else begin
            perf_issued_r <= perf_issued_r + 32'(issue_s);
            perf_stall_r  <= perf_stall_r + 32'(stall_s);
        end
    end

    assign perf_issued = perf_issued_r;
    assign perf_stall  = perf_stall_r;
`endif

endmodule

// File: tb/tb_sha3_perm_scheduler.sv
module tb_sha3_perm_scheduler;
    import sha3_sched_pkg::*;

    localparam int N_REQ        = 4;
    localparam int MAX_INFLIGHT = 8;
    localparam int PERM_LATENCY = 48;

    logic          clk;
    logic          rst_n;
    keccak_state_t perm_state_o, perm_state_i;
    logic          perm_sample_o, perm_good_i, busy, err_orphan;
`ifdef SHA3_PERM_SCHEDULER_PERF_EN
    logic [31:0]   perf_issued, perf_stall;
`endif

    sha3_perm_scheduler_if #(.N_REQ(N_REQ)) bus ();

    sha3_perm_scheduler #(
        .N_REQ        (N_REQ),
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .PERM_LATENCY (PERM_LATENCY)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_bus       (bus.slave),
        .perm_state_o  (perm_state_o),
        .perm_sample_o (perm_sample_o),
        .perm_state_i  (perm_state_i),
        .perm_good_i   (perm_good_i),
        .busy          (busy),
        .err_orphan    (err_orphan)
`ifdef SHA3_PERM_SCHEDULER_PERF_EN
        ,
        .perf_issued   (perf_issued),
        .perf_stall    (perf_stall)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [1599:0] act, input logic [1599:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (low 64 bits)", name, act[63:0], exp[63:0]);
        end
    endtask

    // The model permutation applied by the bench's round chain.
    function automatic keccak_state_t permf(input keccak_state_t x);
        return {x[1598:0], x[1599]} ^ {25{64'h0123_4567_89AB_CDEF}};
    endfunction

    function automatic keccak_state_t mk_state(input int c, input int i);
        logic [63:0] w;
        w = {32'(c), 32'(i)} ^ 64'hC3A5_0F1E_7B29_D486;
        return {25{w}};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- round-chain model: fixed 48-cycle delay ----------------
    int inject_req = 0;
    int inject_done = 0;
    initial begin : chain
        logic [1600:0] ring [PERM_LATENCY];
        int rix;
        rix = 0;
        for (int i = 0; i < PERM_LATENCY; i++) ring[i] = '0;
        perm_good_i  = 1'b0;
        perm_state_i = '0;
        forever begin
            @(negedge clk);
            perm_good_i  = ring[rix][1600];
            perm_state_i = permf(ring[rix][1599:0]);
            if (inject_req != inject_done) begin
                inject_done  = inject_req;
                perm_good_i  = 1'b1;
                perm_state_i = {25{64'hDEAD_BEEF_0BAD_F00D}};
            end
            ring[rix] = {perm_sample_o, perm_state_o};
            rix = (rix + 1) % PERM_LATENCY;
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    int            m_quiet, m_ptr, g, idx;
    int            tq[$];
    keccak_state_t sq[$];
    logic          m_sample, m_err;
    keccak_state_t m_state, m_rsp_s;
    logic [N_REQ-1:0] m_rsp_v, exp_ready;
    int            m_issued, m_stall;
    int            rsp_cnt = 0;
    int            good_cnt = 0;
    int            rsp_order[$];

    initial begin : compare
        forever begin
            @(posedge clk);
            #8;
            if (!rst_n) begin
                m_quiet  = PERM_LATENCY + 1;
                m_ptr    = 0;
                tq.delete();
                sq.delete();
                m_sample = 1'b0;
                m_state  = '0;
                m_rsp_v  = '0;
                m_rsp_s  = '0;
                m_err    = 1'b0;
                m_issued = 0;
                m_stall  = 0;
            end
            g = -1;
            if (rst_n && m_quiet == 0 && tq.size() < MAX_INFLIGHT) begin
                for (int k = 0; k < N_REQ; k++) begin
                    idx = (m_ptr + k) % N_REQ;
                    if (g < 0 && bus.req_valid[idx]) g = idx;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;

            chk("req_ready",     1600'(bus.req_ready), 1600'(exp_ready));
            chk("perm_sample_o", 1600'(perm_sample_o), 1600'(m_sample));
            chk("perm_state_o",  perm_state_o, m_state);
            chk("rsp_valid",     1600'(bus.rsp_valid), 1600'(m_rsp_v));
            chk("rsp_state",     bus.rsp_state, m_rsp_s);
            chk("busy",          1600'(busy), 1600'((m_quiet > 0) || (tq.size() > 0)));
            chk("err_orphan",    1600'(err_orphan), 1600'(m_err));
`ifdef SHA3_PERM_SCHEDULER_PERF_EN
            chk("perf_issued",   1600'(perf_issued), 1600'(m_issued));
            chk("perf_stall",    1600'(perf_stall), 1600'(m_stall));
`endif
            if (bus.rsp_valid != '0) begin
                rsp_cnt++;
                for (int i = 0; i < N_REQ; i++) if (bus.rsp_valid[i]) rsp_order.push_back(i);
            end
            if (rst_n && perm_good_i) good_cnt++;

            if (rst_n) begin
                if (m_quiet == 0 && (|bus.req_valid) && tq.size() >= MAX_INFLIGHT) m_stall++;
                m_sample = (g >= 0);
                m_rsp_v  = '0;
                if (m_quiet == 0 && perm_good_i) begin
                    if (tq.size() > 0) begin
                        m_rsp_v[tq.pop_front()] = 1'b1;
                        m_rsp_s = permf(sq.pop_front());
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (g >= 0) begin
                    m_state = bus.req_state[g*KECCAK_STATE_W +: KECCAK_STATE_W];
                    tq.push_back(g);
                    sq.push_back(m_state);
                    m_ptr = (g + 1) % N_REQ;
                    m_issued++;
                end
                if (m_quiet > 0) m_quiet--;
            end
        end
    end

    // ---------------- stimulus ----------------
    int cyc = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N_REQ; i++)
            bus.req_state[i*KECCAK_STATE_W +: KECCAK_STATE_W] = mk_state(cyc, i);
    endtask

    typedef struct { logic [N_REQ-1:0] v; int n; } pat_t;
    pat_t pats[4] = '{'{4'b1010, 20}, '{4'b0001, 10}, '{4'b0110, 15}, '{4'b1111, 30}};
    int   exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin : main
        int n, ns, k, rsp0, good0;
        logic done;
        rst_n = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < N_REQ; i++)
            bus.req_state[i*KECCAK_STATE_W +: KECCAK_STATE_W] = mk_state(0, i);
        repeat (3) step();

        // QUIET: valid held from release; a stray good at quiet cycle 10
        bus.req_valid = 4'b1111;
        rst_n = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            #5;
            if (bus.req_ready != '0) done = 1'b1;
            else begin
                n++;
                if (n == 10) inject_req++;
                step();
            end
        end
        chk("quiet_len", 1600'(n), 1600'(49));
        chk("quiet_no_orphan", 1600'(err_orphan), 1600'(0));

        // Credit limit: samples before the first result
        ns = 0;
        k = 0;
        while (k < 100) begin
            step();
            #5;
            if (perm_good_i) break;
            if (perm_sample_o) ns++;
            k++;
        end
        chk("samples_at_limit", 1600'(ns), 1600'(MAX_INFLIGHT));
        repeat (60) step();
        for (int i = 0; i < 8; i++) begin
            if (i < rsp_order.size()) chk("rr_order", 1600'(rsp_order[i]), 1600'(exp_order[i]));
            else chk("rr_order_missing", 1600'(rsp_order.size()), 1600'(8));
        end

        // Mixed request patterns
        for (int p = 0; p < 4; p++) begin
            bus.req_valid = pats[p].v;
            repeat (pats[p].n) step();
        end

        // Drain
        bus.req_valid = '0;
        k = 0;
        step();
        #5;
        while (busy && k < 300) begin
            step();
            #5;
            k++;
        end
        chk("drained_busy", 1600'(busy), 1600'(0));

        // Orphan result with nothing in flight
        inject_req++;
        repeat (3) step();
        #5;
        chk("orphan_set", 1600'(err_orphan), 1600'(1));
        repeat (5) step();
        #5;
        chk("orphan_sticky", 1600'(err_orphan), 1600'(1));

        // Reset with 5 in flight; stale results land in QUIET
        step();
        bus.req_valid = 4'b1111;
        repeat (5) step();
        bus.req_valid = '0;
        repeat (3) step();
        #5;
        chk("busy_inflight", 1600'(busy), 1600'(1));
        step();
        rst_n = 1'b0;
        repeat (2) step();
        rsp0  = rsp_cnt;
        good0 = good_cnt;
        rst_n = 1'b1;
        repeat (60) step();
        #5;
        chk("stale_goods_seen", 1600'(good_cnt - good0), 1600'(5));
        chk("stale_no_rsp", 1600'(rsp_cnt - rsp0), 1600'(0));
        chk("stale_no_orphan", 1600'(err_orphan), 1600'(0));

        // Re-issue after the quiet period
        bus.req_valid = 4'b0101;
        repeat (20) step();
        bus.req_valid = '0;
        repeat (60) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
